// File: rtl/mem_bus_arbiter.sv
// Purpose: arbitrates instruction-fetch and load/store requesters onto one memory target, decoding TEXT/DATA/STACK/MMIO regions.
// Latency: request in N, grant in N+1, response in N+2 at the earliest (plus any mem_ack delay); errors always answer in N+2.
// Backpressure: one transaction outstanding; requesters hold req/payload until gnt, the target stalls ACCESS by withholding mem_ack.
module mem_bus_arbiter #(
    parameter int INST_MEM_DEPTH = 1024,
    parameter int DATA_MEM_DEPTH = 1024,
    parameter int MMIO_MEM_SIZE  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_sel,
    output logic [31:0] mem_offset,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] DIV      = 32'(DATA_MEM_DEPTH / 2);
    localparam logic [31:0] MMIO_LO  = 32'h1001_0024;
    localparam logic [31:0] MMIO_HI  = MMIO_LO + 32'(MMIO_MEM_SIZE);   // exclusive
    localparam logic [31:0] DATA_LO  = 32'h1001_0000;
    localparam logic [31:0] DATA_HI  = DATA_LO + DIV - 32'd1;          // inclusive
    localparam logic [31:0] STACK_HI = 32'h7FFF_EFFC;                  // inclusive
    localparam logic [31:0] STACK_LO = STACK_HI - DIV;
    localparam logic [31:0] TEXT_LO  = 32'h0040_0000;
    localparam logic [31:0] TEXT_HI  = TEXT_LO + 32'(INST_MEM_DEPTH);  // exclusive

    localparam logic [1:0] SEL_TEXT  = 2'd0;
    localparam logic [1:0] SEL_DATA  = 2'd1;
    localparam logic [1:0] SEL_STACK = 2'd2;
    localparam logic [1:0] SEL_MMIO  = 2'd3;

    typedef enum logic [1:0] {IDLE, ACCESS, ERROR, RESP} state_t;

    state_t      state, state_nxt;
    logic        any_req, pick_d, legal;
    logic [31:0] req_addr;
    logic        dec_hit;
    logic [1:0]  dec_sel;
    logic [31:0] dec_base;

    // Registered transaction context; last_d = 0 means the instruction side owned the bus last.
    logic        last_d, owner_d, gnt_q, we_q, err_q;
    logic [3:0]  be_q;
    logic [1:0]  sel_q;
    logic [31:0] wdata_q, off_q, rdata_q;

    assign any_req  = i_req | d_req;
    // On a tie, the side that did not own the bus last wins.
    assign pick_d   = d_req & (~i_req | ~last_d);
    assign req_addr = pick_d ? d_addr : i_addr;

    // Region decode; MMIO overlaps DATA and must be tested first.
    always_comb begin
        dec_hit  = 1'b1;
        dec_sel  = SEL_TEXT;
        dec_base = TEXT_LO;
        if (req_addr >= MMIO_LO && req_addr < MMIO_HI) begin
            dec_sel  = SEL_MMIO;
            dec_base = MMIO_LO;
        end else if (req_addr >= DATA_LO && req_addr <= DATA_HI) begin
            dec_sel  = SEL_DATA;
            dec_base = DATA_LO;
        end else if (req_addr >= STACK_LO && req_addr <= STACK_HI) begin
            dec_sel  = SEL_STACK;
            dec_base = STACK_LO;
        end else if (!(req_addr >= TEXT_LO && req_addr < TEXT_HI)) begin
            dec_hit  = 1'b0;
        end
    end

    // Access legality: fetches must be aligned TEXT hits, stores may not touch TEXT.
    always_comb begin
        legal = 1'b0;
        if (pick_d) begin
            legal = dec_hit && !(d_we && dec_sel == SEL_TEXT);
        end else begin
            legal = dec_hit && dec_sel == SEL_TEXT && i_addr[1:0] == 2'b00;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        case (state)
            IDLE:   if (any_req) state_nxt = legal ? ACCESS : ERROR;
            ACCESS: begin
                mem_req = 1'b1;
                if (mem_ack) state_nxt = RESP;
            end
            ERROR:  state_nxt = RESP;
            RESP: begin
                i_rvalid  = ~owner_d;
                d_rvalid  = owner_d;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture owner and payload on leaving IDLE, and the response on ack or error.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d  <= 1'b0;
            owner_d <= 1'b0;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            be_q    <= 4'h0;
            sel_q   <= 2'd0;
            wdata_q <= 32'h0;
            off_q   <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            gnt_q <= 1'b0;
            if (state == IDLE && any_req) begin
                owner_d <= pick_d;
                last_d  <= pick_d;
                gnt_q   <= 1'b1;
                we_q    <= pick_d & d_we;
                be_q    <= pick_d ? d_be : 4'hF;
                wdata_q <= pick_d ? d_wdata : 32'h0;
                sel_q   <= dec_sel;
                off_q   <= req_addr - dec_base;
                err_q   <= ~legal;
                rdata_q <= 32'h0;
            end
            if (state == ACCESS && mem_ack) begin
                rdata_q <= we_q ? 32'h0 : mem_rdata;
            end
        end
    end

    assign i_gnt      = gnt_q & ~owner_d;
    assign d_gnt      = gnt_q & owner_d;
    assign i_rdata    = rdata_q;
    assign d_rdata    = rdata_q;
    assign i_err      = i_rvalid & err_q;
    assign d_err      = d_rvalid & err_q;
    assign mem_we     = mem_req & we_q;
    assign mem_be     = be_q;
    assign mem_wdata  = wdata_q;
    assign mem_sel    = sel_q;
    assign mem_offset = off_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose: directed bench for mem_bus_arbiter with a response scoreboard and a simple target model.
// Latency: checks grant at N+1 and response at N+2 plus any target delay.
// Backpressure: target model withholds mem_ack for a programmable number of cycles.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_gnt, i_rvalid, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_offset, mem_rdata;
    logic [1:0]  mem_sel;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ack_delay = 0;
    int          ack_wait = 0;
    logic [31:0] ack_data = 32'h0;
    logic        force_ack = 1'b0;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_sel(mem_sel), .mem_offset(mem_offset), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Target model: acks ack_delay cycles after mem_req rises, or on force_ack.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (force_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = ack_data;
            end else if (mem_req === 1'b1) begin
                if (ack_wait >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = ack_data;
                    ack_wait  = 0;
                end else begin
                    ack_wait++;
                end
            end else begin
                ack_wait = 0;
            end
        end
    end

    // Response monitor: every rvalid pops and compares one scoreboard entry.
    initial forever begin
        @(negedge clk);
        if (i_rvalid === 1'b1 || d_rvalid === 1'b1) begin
            check("single_rvalid", {31'b0, i_rvalid & d_rvalid}, 32'h0);
            if (sb.size() == 0) begin
                check("unexpected_rvalid", {31'b0, i_rvalid | d_rvalid}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_owner", {31'b0, d_rvalid}, {31'b0, e.is_d});
                check("resp_rdata", d_rvalid ? d_rdata : i_rdata, e.rdata);
                check("resp_err", {31'b0, d_rvalid ? d_err : i_err}, {31'b0, e.err});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_payload(input string tag, input logic is_d, input logic we, input logic [3:0] be,
                                 input logic [31:0] wdata, input logic [1:0] exp_sel, input logic [31:0] exp_off);
        check({tag, "/mem_sel"}, {30'b0, mem_sel}, {30'b0, exp_sel});
        check({tag, "/mem_offset"}, mem_offset, exp_off);
        check({tag, "/mem_we"}, {31'b0, mem_we}, {31'b0, we});
        check({tag, "/mem_be"}, {28'b0, mem_be}, {28'b0, is_d ? be : 4'hF});
        if (is_d) check({tag, "/mem_wdata"}, mem_wdata, wdata);
    endtask

    task automatic run_txn(input string tag, input logic is_d, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata, input int delay,
                           input logic [31:0] rdat, input logic [1:0] exp_sel, input logic [31:0] exp_off,
                           input logic exp_err);
        int   req_cyc;
        logic got;
        exp_t e;
        e.is_d    = is_d;
        e.err     = exp_err;
        e.rdata   = (exp_err || we) ? 32'h0 : rdat;
        ack_delay = delay;
        ack_data  = rdat;
        @(posedge clk);
        #1;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        sb.push_back(e);
        req_cyc = cyc;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if ((is_d ? d_gnt : i_gnt) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "/gnt_seen"}, {31'b0, got}, 32'h1);
        check({tag, "/gnt_latency"}, cyc - req_cyc, 32'd1);
        check({tag, "/other_gnt"}, {31'b0, is_d ? i_gnt : d_gnt}, 32'h0);
        check({tag, "/mem_req"}, {31'b0, mem_req}, {31'b0, !exp_err});
        if (!exp_err) check_payload(tag, is_d, we, be, wdata, exp_sel, exp_off);
        @(posedge clk);
        #1;
        i_req = 1'b0;
        d_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (exp_err) check({tag, "/no_mem_req"}, {31'b0, mem_req}, 32'h0);
            else if (mem_req === 1'b1) check_payload({tag, "/hold"}, is_d, we, be, wdata, exp_sel, exp_off);
            if ((is_d ? d_rvalid : i_rvalid) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "/resp_seen"}, {31'b0, got}, 32'h1);
        check({tag, "/resp_latency"}, cyc - req_cyc, 32'(exp_err ? 2 : 2 + delay));
    endtask

    initial begin
        logic got;
        rst = 1'b1;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values.
        @(negedge clk);
        check("rst/i_gnt", {31'b0, i_gnt}, 32'h0);
        check("rst/d_gnt", {31'b0, d_gnt}, 32'h0);
        check("rst/i_rvalid", {31'b0, i_rvalid}, 32'h0);
        check("rst/d_rvalid", {31'b0, d_rvalid}, 32'h0);
        check("rst/i_err", {31'b0, i_err}, 32'h0);
        check("rst/d_err", {31'b0, d_err}, 32'h0);
        check("rst/mem_req", {31'b0, mem_req}, 32'h0);
        check("rst/mem_we", {31'b0, mem_we}, 32'h0);
        check("rst/i_rdata", i_rdata, 32'h0);
        check("rst/d_rdata", d_rdata, 32'h0);
        check("rst/mem_be", {28'b0, mem_be}, 32'h0);
        check("rst/mem_wdata", mem_wdata, 32'h0);
        check("rst/mem_offset", mem_offset, 32'h0);
        check("rst/mem_sel", {30'b0, mem_sel}, 32'h0);

        // Both requesters held high: data wins the first tie, then strict alternation.
        ack_delay = 0;
        ack_data  = 32'hCAFE_F00D;
        for (int g = 0; g < 4; g++) begin
            exp_t e;
            e.is_d  = (g % 2 == 0);
            e.rdata = 32'hCAFE_F00D;
            e.err   = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        i_req = 1'b1; i_addr = 32'h0040_0010;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h1001_0020;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (i_gnt === 1'b1 || d_gnt === 1'b1) begin
                    got = 1'b1;
                    break;
                end
            end
            check("tie/gnt_seen", {31'b0, got}, 32'h1);
            check("tie/gnt_order", {31'b0, d_gnt}, {31'b0, g % 2 == 0});
            check("tie/gnt_excl", {31'b0, i_gnt & d_gnt}, 32'h0);
            check("tie/mem_sel", {30'b0, mem_sel}, (g % 2 == 0) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        #1;
        i_req = 1'b0;
        d_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check("tie/drained", sb.size(), 32'h0);

        //       tag                 d  we  be     addr          wdata         dly rdata         sel  offset        err
        run_txn("fetch_text",        0, 0, 4'hF, 32'h0040_0010, 32'h0,        0, 32'hDEAD_BEEF, 2'd0, 32'h10,  0);
        run_txn("load_mmio",         1, 0, 4'hF, 32'h1001_0028, 32'h0,        0, 32'h1111_2222, 2'd3, 32'h4,   0);
        run_txn("load_data",         1, 0, 4'hF, 32'h1001_0020, 32'h0,        0, 32'h3333_4444, 2'd1, 32'h20,  0);
        run_txn("load_stack_lo",     1, 0, 4'hF, 32'h7FFF_EDFC, 32'h0,        0, 32'h5555_6666, 2'd2, 32'h0,   0);
        run_txn("load_stack_hi",     1, 0, 4'hF, 32'h7FFF_EFFC, 32'h0,        0, 32'h7777_8888, 2'd2, 32'h200, 0);
        run_txn("load_data_hi",      1, 0, 4'h1, 32'h1001_01FF, 32'h0,        0, 32'h0000_00AB, 2'd1, 32'h1FF, 0);
        run_txn("load_past_mmio",    1, 0, 4'hF, 32'h1001_0034, 32'h0,        0, 32'h9999_AAAA, 2'd1, 32'h34,  0);
        run_txn("load_text",         1, 0, 4'hF, 32'h0040_0008, 32'h0,        0, 32'hBBBB_CCCC, 2'd0, 32'h8,   0);
        run_txn("store_data",        1, 1, 4'h3, 32'h1001_0040, 32'h1234_5678, 1, 32'h55AA_55AA, 2'd1, 32'h40,  0);
        run_txn("store_text_err",    1, 1, 4'hF, 32'h0040_0000, 32'hFFFF_0000, 0, 32'h0,        2'd0, 32'h0,   1);
        run_txn("fetch_oob_err",     0, 0, 4'hF, 32'h0040_0400, 32'h0,        0, 32'h0,        2'd0, 32'h0,   1);
        run_txn("fetch_misalign_err",0, 0, 4'hF, 32'h0040_0002, 32'h0,        0, 32'h0,        2'd0, 32'h0,   1);
        run_txn("fetch_data_err",    0, 0, 4'hF, 32'h1001_0000, 32'h0,        0, 32'h0,        2'd0, 32'h0,   1);
        run_txn("load_miss_err",     1, 0, 4'hF, 32'h2000_0000, 32'h0,        0, 32'h0,        2'd0, 32'h0,   1);
        run_txn("load_slow",         1, 0, 4'hF, 32'h1001_0100, 32'h0,        5, 32'h0BAD_F00D, 2'd1, 32'h100, 0);

        // Reset in the middle of ACCESS, then a stray ack: no response may appear.
        ack_delay = 1000;
        @(posedge clk);
        #1;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h1001_0100;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (d_gnt === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("rst_mid/gnt_seen", {31'b0, got}, 32'h1);
        @(posedge clk);
        #1 d_req = 1'b0;
        @(negedge clk);
        check("rst_mid/mem_req_before", {31'b0, mem_req}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid/mem_req_after", {31'b0, mem_req}, 32'h0);
        @(posedge clk);
        #1 force_ack = 1'b1;
        ack_data = 32'hBAD0_BAD0;
        @(posedge clk);
        #1 force_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_mid/no_rvalid", {31'b0, i_rvalid | d_rvalid}, 32'h0);
            check("rst_mid/no_mem_req", {31'b0, mem_req}, 32'h0);
        end
        ack_delay = 0;
        run_txn("fetch_after_rst",   0, 0, 4'hF, 32'h0040_03FC, 32'h0,        0, 32'h600D_CAFE, 2'd0, 32'h3FC, 0);

        repeat (3) @(negedge clk);
        check("final/scoreboard_empty", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter INST_MEM_DEPTH, default 1024, text region size in bytes.
REQ-002 Parameter DATA_MEM_DEPTH, default 1024, data+stack size in bytes; DIV = DATA_MEM_DEPTH/2.
REQ-003 Parameter MMIO_MEM_SIZE, default 16, MMIO region size in bytes.
REQ-004 Ports: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high
- i_req  in  1  fetch request
- i_addr  in  32  fetch address
- i_gnt  out  1  fetch grant pulse
- i_rvalid  out  1  fetch response pulse
- i_rdata  out  32  fetch data
- i_err  out  1  fetch error, valid with i_rvalid
- d_req  in  1  load/store request
- d_we  in  1  1 = store
- d_be  in  4  byte enables
- d_addr  in  32  load/store address
- d_wdata  in  32  store data
- d_gnt  out  1  data grant pulse
- d_rvalid  out  1  data response pulse
- d_rdata  out  32  load data
- d_err  out  1  data error, valid with d_rvalid
- mem_req  out  1  target request, held until mem_ack
- mem_we, mem_be[3:0], mem_wdata[31:0]  out  target write controls
- mem_sel  out  2  region: 0 TEXT, 1 DATA, 2 STACK, 3 MMIO
- mem_offset  out  32  address minus region base
- mem_ack  in  1  target completion, 1-cycle pulse
- mem_rdata  in  32  target read data, valid with mem_ack

Function
REQ-005 Requesters SHALL hold req and payload stable until their gnt pulse; the arbiter SHALL register the payload in the cycle it leaves IDLE.
REQ-006 FSM states SHALL be IDLE, ACCESS, ERROR, RESP.
REQ-007 Decode, highest priority first: MMIO [0x10010024, +MMIO_MEM_SIZE) exclusive top; DATA [0x10010000, 0x10010000+DIV-1] inclusive; STACK [0x7FFFEFFC-DIV, 0x7FFFEFFC] inclusive; TEXT [0x00400000, +INST_MEM_DEPTH) exclusive top; any other address is a decode miss.
REQ-008 mem_offset SHALL equal address minus the selected region's lower bound, modulo 2^32.
REQ-009 Errors: decode miss; fetch outside TEXT; fetch with addr[1:0] != 0; store into TEXT. Data loads from TEXT SHALL be legal.
REQ-010 IDLE, cycle N, any req high: select owner; next state ACCESS if legal else ERROR; owner's gnt pulses in N+1.
REQ-011 Simultaneous i_req and d_req: grant the requester not granted most recently; last-owner register resets to "instruction", so data wins the first tie.
REQ-012 ACCESS: mem_req=1 with registered we/be/wdata/sel/offset (mem_we=0, mem_be=4'hF for fetch) until mem_ack; on mem_ack capture mem_rdata and go to RESP.
REQ-013 ERROR: mem_req=0 for one cycle, then RESP with err=1 and rdata=0.
REQ-014 RESP: owner's rvalid=1 for exactly one cycle with registered rdata/err; next state IDLE; new requests sampled only in IDLE.
REQ-015 Minimum latency: req in N, gnt N+1, rvalid N+2 (mem_ack in N+1); error response always at N+2.
REQ-016 mem_ack outside ACCESS SHALL be ignored; rdata of stores SHALL be 0.
REQ-017 Only one transaction outstanding; the non-owner's gnt/rvalid SHALL stay 0.

Reset
REQ-018 rst in any state, including mid-ACCESS, SHALL force IDLE next cycle, drop mem_req, and suppress any pending rvalid.
REQ-019 Reset values: all gnt, rvalid, err, mem_req, mem_we = 0; rdata, mem_be, mem_wdata, mem_offset = 0; mem_sel = 0; last-owner = instruction.

Verification
REQ-020 i_req, i_addr=0x00400010, mem_ack in N+1 with 0xDEADBEEF -> i_gnt N+1, mem_sel=0, mem_offset=0x10, i_rvalid N+2, i_rdata=0xDEADBEEF, i_err=0.
REQ-021 d_req load 0x10010028 -> mem_sel=3, mem_offset=0x4; load 0x10010020 -> mem_sel=1, offset=0x20; load 0x7FFFEDFC -> mem_sel=2, offset=0.
REQ-022 d_req store to 0x00400000 -> d_gnt, no mem_req, d_rvalid with d_err=1 at N+2; i_addr=0x00400400 or 0x00400002 -> i_err=1.
REQ-023 i_req and d_req held high together -> grants alternate D, I, D, I.
REQ-024 mem_ack withheld 5 cycles -> mem_req held, payload stable, rvalid one cycle after ack.
REQ-025 rst during ACCESS, then late mem_ack -> IDLE, mem_req=0, no rvalid emitted.
